md_scheduler: RTL and testbench

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler.sv | 88 ++++++++
 tb/tb_md_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// HI/LO scheduler: issues mult/div to external units, owns the HI/LO registers
// and stalls EX while a multi-cycle op is in flight.
module md_scheduler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [1:0]  MULT,
    input  logic [1:0]  DIV,
    input  logic [1:0]  MFHL,
    input  logic [1:0]  MTHL,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_signed,
    output logic        mul_req,
    input  logic [63:0] mul_prod,
    output logic        div_req,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        md_stall,
    output logic [31:0] hilo_rdata
);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DIV_WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] hi, lo;
    logic        busy, hl_op, issue, issue_mul, issue_div, issue_mthl;

    assign busy       = (state != IDLE);
    assign hl_op      = (|MULT) | (|DIV) | (|MFHL) | (|MTHL);
    assign issue      = ex_valid & ~flush & ~busy & hl_op;
    // MULT wins over an illegal MULT+DIV encoding
    assign issue_mul  = issue & (|MULT);
    assign issue_div  = issue & ~(|MULT) & (|DIV);
    assign issue_mthl = issue & ~(|MULT) & ~(|DIV) & (|MTHL);

    assign div_req    = (state == DIV_WAIT);
    assign md_stall   = ex_valid & busy & hl_op;
    assign hilo_rdata = MFHL[1] ? hi : lo;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (issue_mul) state_nxt = MUL1;
                      else if (issue_div) state_nxt = DIV_WAIT;
            MUL1:     state_nxt = MUL2;
            MUL2:     state_nxt = IDLE;
            DIV_WAIT: if (div_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            mul_req   <= 1'b0;
        end else begin
            state   <= state_nxt;
            mul_req <= issue_mul;
            // operands stay frozen for the whole op; issue only happens from IDLE
            if (issue_mul || issue_div) begin
                op_a      <= src_a;
                op_b      <= src_b;
                op_signed <= issue_mul ? MULT[0] : DIV[0];
            end
            if (state == MUL2) begin
                hi <= mul_prod[63:32];
                lo <= mul_prod[31:0];
            end else if (state == DIV_WAIT && div_done) begin
                hi <= div_r;
                lo <= div_q;
            end else if (issue_mthl) begin
                if (MTHL[1]) hi <= src_a;
                if (MTHL[0]) lo <= src_a;
            end
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: directed scenarios with literal expectations plus
// random traffic compared every cycle against a behavioural HI/LO model.
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, flush, div_done;
    logic [1:0]  MULT, DIV, MFHL, MTHL;
    logic [31:0] src_a, src_b, div_q, div_r;
    logic [31:0] op_a, op_b, hilo_rdata;
    logic        op_signed, mul_req, div_req, md_stall;
    logic [63:0] mul_prod;

    int n_pass = 0;
    int n_tot  = 0;
    logic chk_en = 1'b0;

    // behavioural model: pending op kind (0 none, 1 mult, 2 div) and cycles to go
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic        m_s, m_mreq;
    int          m_kind, m_left;

    always #5 clk = ~clk;

    md_scheduler dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .MULT(MULT), .DIV(DIV),
        .MFHL(MFHL), .MTHL(MTHL), .src_a(src_a), .src_b(src_b), .flush(flush),
        .op_a(op_a), .op_b(op_b), .op_signed(op_signed), .mul_req(mul_req),
        .mul_prod(mul_prod), .div_req(div_req), .div_done(div_done),
        .div_q(div_q), .div_r(div_r), .md_stall(md_stall), .hilo_rdata(hilo_rdata)
    );

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // the external multiplier: product of the latched operands
    assign mul_prod = prod(m_a, m_b, m_s);

    function automatic logic hl_any();
        return (|MULT) || (|DIV) || (|MFHL) || (|MTHL);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hi <= '0; m_lo <= '0; m_a <= '0; m_b <= '0;
            m_s <= 1'b0; m_mreq <= 1'b0; m_kind <= 0; m_left <= 0;
        end else begin
            m_mreq <= 1'b0;
            if (m_kind == 1) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= prod(m_a, m_b, m_s) >> 32;
                    m_lo   <= prod(m_a, m_b, m_s) & 64'hFFFF_FFFF;
                    m_kind <= 0;
                end
            end else if (m_kind == 2) begin
                if (div_done) begin
                    m_lo <= div_q; m_hi <= div_r; m_kind <= 0;
                end
            end else if (ex_valid && !flush && hl_any()) begin
                if (|MULT) begin
                    m_a <= src_a; m_b <= src_b; m_s <= MULT[0];
                    m_kind <= 1; m_left <= 2; m_mreq <= 1'b1;
                end else if (|DIV) begin
                    m_a <= src_a; m_b <= src_b; m_s <= DIV[0]; m_kind <= 2;
                end else begin
                    if (MTHL[1]) m_hi <= src_a;
                    if (MTHL[0]) m_lo <= src_a;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("op_a", 64'(op_a), 64'(m_a));
            chk("op_b", 64'(op_b), 64'(m_b));
            chk("op_signed", 64'(op_signed), 64'(m_s));
            chk("mul_req", 64'(mul_req), 64'(m_mreq));
            chk("div_req", 64'(div_req), 64'(m_kind == 2));
            chk("md_stall", 64'(md_stall), 64'(ex_valid && m_kind != 0 && hl_any()));
            chk("hilo_rdata", 64'(hilo_rdata), 64'(MFHL[1] ? m_hi : m_lo));
        end
    end

    task automatic drv(input logic ev, input logic [1:0] mu, input logic [1:0] dv,
                       input logic [1:0] mf, input logic [1:0] mt,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
        ex_valid = ev; MULT = mu; DIV = dv; MFHL = mf; MTHL = mt;
        src_a = a; src_b = b; flush = fl; div_done = 1'b0;
    endtask

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    initial begin
        int cnt;
        int r;
        resetn = 1'b0;
        div_q = '0; div_r = '0;
        drv(0, 0, 0, 2'b10, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst op_a", 64'(op_a), 64'h0);
        chk("rst mul_req", 64'(mul_req), 64'h0);
        chk("rst div_req", 64'(div_req), 64'h0);
        chk("rst hi", 64'(hilo_rdata), 64'h0);
        resetn = 1'b1;
        chk_en = 1'b1;
        nxt();

        // signed mult -7*3, then dependent mflo
        drv(1, 2'b01, 0, 0, 0, 32'hFFFF_FFF9, 32'd3, 0);
        nxt();
        drv(1, 0, 0, 2'b01, 0, 0, 0, 0);
        mid(); chk("mul stall1", 64'(md_stall), 64'h1); chk("mul_req pulse", 64'(mul_req), 64'h1);
        nxt();
        mid(); chk("mul stall2", 64'(md_stall), 64'h1); chk("mul_req low", 64'(mul_req), 64'h0);
        nxt();
        mid(); chk("mul stall3", 64'(md_stall), 64'h0); chk("mflo", 64'(hilo_rdata), 64'hFFFF_FFEB);
        nxt();
        drv(0, 0, 0, 2'b10, 0, 0, 0, 0);
        mid(); chk("mul hi", 64'(hilo_rdata), 64'hFFFF_FFFF);
        nxt();

        // divu 100/7, done on the 10th DIV_WAIT cycle, mfhi waiting
        drv(1, 0, 2'b10, 0, 0, 32'd100, 32'd7, 0);
        nxt();
        drv(1, 0, 0, 2'b10, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) begin div_done = 1'b1; div_q = 32'd14; div_r = 32'd2; end
            mid(); if (div_req) cnt++;
            nxt();
        end
        div_done = 1'b0;
        mid();
        chk("div_req cycles", 64'(cnt), 64'd10);
        chk("div stall off", 64'(md_stall), 64'h0);
        chk("mfhi div", 64'(hilo_rdata), 64'd2);
        chk("divu unsigned", 64'(op_signed), 64'h0);
        nxt();
        drv(0, 0, 0, 2'b01, 0, 0, 0, 0);
        mid(); chk("div lo", 64'(hilo_rdata), 64'd14);
        nxt();

        // mthi under flush, then without
        drv(1, 0, 0, 0, 2'b10, 32'h1234_5678, 0, 1);
        nxt();
        drv(0, 0, 0, 2'b10, 0, 0, 0, 0);
        mid(); chk("mthi flushed", 64'(hilo_rdata), 64'd2);
        nxt();
        drv(1, 0, 0, 0, 2'b10, 32'h1234_5678, 0, 0);
        nxt();
        drv(0, 0, 0, 2'b10, 0, 0, 0, 0);
        mid(); chk("mthi", 64'(hilo_rdata), 64'h1234_5678);
        nxt();

        // back-to-back multu then mult
        drv(1, 2'b10, 0, 0, 0, 32'd5, 32'd6, 0);
        nxt();
        drv(1, 2'b01, 0, 0, 0, 32'd7, 32'd8, 0);
        mid(); chk("b2b stall1", 64'(md_stall), 64'h1); chk("b2b op_a1", 64'(op_a), 64'd5);
        nxt();
        mid(); chk("b2b stall2", 64'(md_stall), 64'h1); chk("b2b op_a2", 64'(op_a), 64'd5);
        nxt();
        mid(); chk("b2b stall3", 64'(md_stall), 64'h0); chk("b2b op_a3", 64'(op_a), 64'd5);
        nxt();
        drv(0, 0, 0, 2'b01, 0, 0, 0, 0);
        mid(); chk("b2b op_a new", 64'(op_a), 64'd7); chk("b2b lo1", 64'(hilo_rdata), 64'd30);
        nxt(); nxt();
        mid(); chk("b2b lo2", 64'(hilo_rdata), 64'd56);
        nxt();

        // flush during MUL1 with a competing mtlo
        drv(1, 2'b01, 0, 0, 0, 32'd3, 32'd4, 0);
        nxt();
        drv(1, 0, 0, 0, 2'b01, 32'hDEAD_BEEF, 0, 1);
        mid(); chk("flush mul1 stall", 64'(md_stall), 64'h1);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        drv(0, 0, 0, 2'b01, 0, 0, 0, 0);
        mid(); chk("flush lo", 64'(hilo_rdata), 64'd12);
        MFHL = 2'b10;
        #1 chk("flush hi", 64'(hilo_rdata), 64'd0);
        nxt();

        // reset while waiting on the divider
        drv(1, 0, 2'b01, 0, 0, 32'd50, 32'd5, 0);
        nxt();
        drv(0, 0, 0, 2'b01, 0, 0, 0, 0);
        nxt(); nxt();
        mid(); chk("div_req pre-rst", 64'(div_req), 64'h1);
        #1 resetn = 1'b0;
        #1 chk("rst div_req", 64'(div_req), 64'h0); chk("rst lo", 64'(hilo_rdata), 64'h0);
        MFHL = 2'b10;
        #1 chk("rst hi async", 64'(hilo_rdata), 64'h0);
        nxt();
        resetn = 1'b1;
        div_done = 1'b1; div_q = 32'd99; div_r = 32'd98;
        mid(); chk("late done req", 64'(div_req), 64'h0);
        nxt();
        div_done = 1'b0;
        mid(); chk("late done hi", 64'(hilo_rdata), 64'h0);
        nxt();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            drv(($urandom % 4) != 0, 0, 0, 0, 0, $urandom, $urandom, ($urandom % 8) == 0);
            case (r)
                0, 1: MULT = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                2, 3: DIV  = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                4, 5: MFHL = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                6, 7: MTHL = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                9: begin MULT = 2'b01; DIV = 2'b10; end
                default: ;
            endcase
            if (r == 8) src_b = 32'd0;
            div_done = ($urandom % 5) == 0;
            div_q = $urandom; div_r = $urandom;
            resetn = ($urandom % 500) != 0;
            nxt();
            resetn = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
